// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the IF/ID pipeline register.
// Owns the PC, issues icache reads, and buffers one returned instruction
// while decode is stalled. Applies downstream redirects and halt.
module fetch_unit #(
  parameter int unsigned WORD_W  = 32,
  parameter logic [WORD_W-1:0] PC_INIT = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic [WORD_W-1:0] imemload,
  output logic              imemREN,
  output logic [WORD_W-1:0] imemaddr,
  input  logic              id_stall,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic [WORD_W-1:0] if_instr,
  output logic [WORD_W-1:0] if_pc,
  output logic [WORD_W-1:0] if_npc
);

  localparam int unsigned    INSTR_BYTES = 4;
  localparam logic [WORD_W-1:0] PC_STEP  = WORD_W'(INSTR_BYTES);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state, next_state;
  logic [WORD_W-1:0] pc, next_pc;
  logic [WORD_W-1:0] hold_instr, next_hold;
  logic [WORD_W-1:0] pc_plus4;

  // Sequential PC increment; wraps silently at the top of the address space.
  assign pc_plus4 = pc + PC_STEP;

  // State, PC and hold-buffer registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= FETCH;
      pc         <= PC_INIT;
      hold_instr <= '0;
    end else begin
      state      <= next_state;
      pc         <= next_pc;
      hold_instr <= next_hold;
    end
  end

  // Next-state and combinational IF/ID / icache outputs.
  always_comb begin
    next_state  = state;
    next_pc     = pc;
    next_hold   = hold_instr;
    imemREN     = 1'b0;
    imemaddr    = pc;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    if_instr    = hold_instr;
    if_pc       = pc;
    if_npc      = pc_plus4;

    unique case (state)
      FETCH: begin
        imemREN  = 1'b1;
        if_instr = imemload;
        if (ihit && !id_stall) begin
          if_id_en = 1'b1;
          next_pc  = pc_plus4;
        end else if (ihit) begin
          // Decode busy: park the returned word and stop reading.
          next_hold  = imemload;
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (!id_stall) begin
          if_id_en   = 1'b1;
          next_pc    = pc_plus4;
          next_state = FETCH;
        end
      end
      HALTED: begin
        // Fetch frozen until reset.
      end
      default: begin
        next_state = FETCH;
      end
    endcase

    // Halt and redirect override normal flow; halt wins and keeps the PC.
    if (state != HALTED) begin
      if (halt) begin
        imemREN     = 1'b0;
        if_id_en    = 1'b1;
        if_id_flush = 1'b1;
        next_pc     = pc;
        next_hold   = hold_instr;
        next_state  = HALTED;
      end else if (redirect) begin
        // Same-cycle ihit is discarded; target used exactly as given.
        imemREN     = 1'b0;
        if_id_en    = 1'b1;
        if_id_flush = 1'b1;
        next_pc     = redirect_pc;
        next_hold   = '0;
        next_state  = FETCH;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for the fetch stage.
module tb_fetch_unit;

  logic        CLK;
  logic        RST;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        id_stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        if_id_en;
  logic        if_id_flush;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_npc;

  int n_cmp;
  int n_mis;

  typedef struct {
    string       tag;
    logic        ren;
    logic [31:0] addr;
    logic        en;
    logic        flush;
    logic        chk_instr;
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];

  fetch_unit #(.WORD_W(32), .PC_INIT(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .id_stall(id_stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .if_id_en(if_id_en), .if_id_flush(if_id_flush), .if_instr(if_instr),
    .if_pc(if_pc), .if_npc(if_npc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs; optionally push an expectation and check it mid-cycle.
  task automatic cyc(input string tag, input logic rst, input logic h,
                     input logic [31:0] ld, input logic st, input logic rd,
                     input logic [31:0] rpc, input logic hl, input logic do_chk,
                     input logic e_ren, input logic [31:0] e_addr,
                     input logic e_en, input logic e_fl,
                     input logic e_ci, input logic [31:0] e_instr,
                     input logic [31:0] e_pc);
    exp_t e;
    exp_t g;
    RST = rst; ihit = h; imemload = ld; id_stall = st;
    redirect = rd; redirect_pc = rpc; halt = hl;
    if (do_chk) begin
      e.tag = tag; e.ren = e_ren; e.addr = e_addr; e.en = e_en;
      e.flush = e_fl; e.chk_instr = e_ci; e.instr = e_instr; e.pc = e_pc;
      sb.push_back(e);
    end
    @(negedge CLK);
    if (sb.size() != 0) begin
      g = sb.pop_front();
      chk({g.tag, ".ren"},   32'(imemREN),     32'(g.ren));
      chk({g.tag, ".addr"},  imemaddr,         g.addr);
      chk({g.tag, ".en"},    32'(if_id_en),    32'(g.en));
      chk({g.tag, ".flush"}, 32'(if_id_flush), 32'(g.flush));
      chk({g.tag, ".pc"},    if_pc,            g.pc);
      chk({g.tag, ".npc"},   if_npc,           g.pc + 32'd4);
      if (g.chk_instr) chk({g.tag, ".instr"}, if_instr, g.instr);
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    RST = 1'b1; ihit = 1'b0; imemload = '0; id_stall = 1'b0;
    redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    @(posedge CLK);
    #1;

    // Reset state: FETCH at PC_INIT, no write.
    cyc("rst", 1, 0, 32'h0, 0, 0, 32'h0, 0, 0,  0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    cyc("rst_state", 0, 0, 32'hDEAD_BEEF, 0, 0, 32'h0, 0, 1,
        1, 32'h0, 0, 0, 1, 32'hDEAD_BEEF, 32'h0);

    // 1. Streaming fetch, one instruction per ihit.
    cyc("t1_0", 0, 1, 32'h1000_0000, 0, 0, 32'h0, 0, 1, 1, 32'h0, 1, 0, 1, 32'h1000_0000, 32'h0);
    cyc("t1_4", 0, 1, 32'h1000_0001, 0, 0, 32'h0, 0, 1, 1, 32'h4, 1, 0, 1, 32'h1000_0001, 32'h4);
    cyc("t1_8", 0, 1, 32'h1000_0002, 0, 0, 32'h0, 0, 1, 1, 32'h8, 1, 0, 1, 32'h1000_0002, 32'h8);
    cyc("t1_c", 0, 1, 32'h1000_0003, 0, 0, 32'h0, 0, 1, 1, 32'hC, 1, 0, 1, 32'h1000_0003, 32'hC);

    // 2. Redirect back to 8, then stall decode for 3 cycles.
    cyc("t2_redir", 0, 0, 32'h0, 0, 1, 32'h8, 0, 1, 0, 32'h10, 1, 1, 0, 32'h0, 32'h10);
    cyc("t2_hit",  0, 1, 32'h2002_0005, 1, 0, 32'h0, 0, 1, 1, 32'h8, 0, 0, 1, 32'h2002_0005, 32'h8);
    cyc("t2_hold1", 0, 1, 32'h1111_1111, 1, 0, 32'h0, 0, 1, 0, 32'h8, 0, 0, 1, 32'h2002_0005, 32'h8);
    cyc("t2_hold2", 0, 1, 32'h2222_2222, 1, 0, 32'h0, 0, 1, 0, 32'h8, 0, 0, 1, 32'h2002_0005, 32'h8);
    cyc("t2_rel",  0, 0, 32'h3333_3333, 0, 0, 32'h0, 0, 1, 0, 32'h8, 1, 0, 1, 32'h2002_0005, 32'h8);
    cyc("t2_next", 0, 1, 32'h4444_4444, 0, 0, 32'h0, 0, 1, 1, 32'hC, 1, 0, 1, 32'h4444_4444, 32'hC);

    // 3. Redirect with a simultaneous ihit at pc=0x10.
    cyc("t3_redir", 0, 1, 32'h5555_5555, 0, 1, 32'h40, 0, 1, 0, 32'h10, 1, 1, 0, 32'h0, 32'h10);
    cyc("t3_tgt",  0, 0, 32'h6666_6666, 0, 0, 32'h0, 0, 1, 1, 32'h40, 0, 0, 1, 32'h6666_6666, 32'h40);

    // 4. Redirect while in HOLD with decode still stalled.
    cyc("t4_hit",  0, 1, 32'hAAAA_AAAA, 1, 0, 32'h0, 0, 1, 1, 32'h40, 0, 0, 1, 32'hAAAA_AAAA, 32'h40);
    cyc("t4_redir", 0, 0, 32'h0, 1, 1, 32'h100, 0, 1, 0, 32'h40, 1, 1, 0, 32'h0, 32'h40);
    cyc("t4_tgt",  0, 0, 32'h0000_0055, 1, 0, 32'h0, 0, 1, 1, 32'h100, 0, 0, 1, 32'h0000_0055, 32'h100);

    // 5. Halt beats redirect; fetch stays frozen until reset.
    cyc("t5_halt", 0, 1, 32'h7777_7777, 0, 1, 32'h200, 1, 1, 0, 32'h100, 1, 1, 0, 32'h0, 32'h100);
    cyc("t5_h1", 0, 1, 32'h0, 0, 1, 32'h300, 0, 1, 0, 32'h100, 0, 0, 0, 32'h0, 32'h100);
    cyc("t5_h2", 0, 1, 32'h0, 0, 0, 32'h0, 1, 1, 0, 32'h100, 0, 0, 0, 32'h0, 32'h100);
    cyc("t5_h3", 0, 0, 32'h0, 1, 1, 32'h400, 1, 1, 0, 32'h100, 0, 0, 0, 32'h0, 32'h100);
    cyc("t5_rst", 1, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    cyc("t5_post", 0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 1, 32'h0, 0, 0, 0, 32'h0, 32'h0);

    // 6. PC wraps from the last word to zero.
    cyc("t6_redir", 0, 0, 32'h0, 0, 1, 32'hFFFF_FFFC, 0, 1, 0, 32'h0, 1, 1, 0, 32'h0, 32'h0);
    cyc("t6_top",  0, 1, 32'h8888_8888, 0, 0, 32'h0, 0, 1, 1, 32'hFFFF_FFFC, 1, 0, 1, 32'h8888_8888, 32'hFFFF_FFFC);
    cyc("t6_wrap", 0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 1, 32'h0, 0, 0, 0, 32'h0, 32'h0);

    if (sb.size() != 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
